// File: rtl/mem_access_unit.sv
// Data-memory access stage: takes one load/store from EX, drives a
// ready-handshaked RAM port with wait states and a timeout, and returns
// aligned, extended load data (or an exception) to WB.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic                      req_sign_ext,
  input  logic [1:0]                req_size,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic                      flush,
  output logic                      ram_en,
  output logic [DATA_WIDTH/8-1:0]   ram_write_en,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_write_data,
  input  logic                      ram_ready,
  input  logic [DATA_WIDTH-1:0]     ram_read_data,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      exc_valid,
  output logic [1:0]                exc_code,
  output logic [ADDR_WIDTH-1:0]     exc_addr
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] MAX_SIZE = (DATA_WIDTH == 64) ? 2'd3 : 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte-lane strobes covering 2^size bytes starting at lane 'off'.
  function automatic logic [LANES-1:0] lane_strobe(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] off);
    logic [LANES-1:0] s;
    int nbytes;
    int first;
    s      = {LANES{1'b0}};
    nbytes = 32'sd1 << size;
    first  = int'(off);
    for (int i = 0; i < LANES; i++) begin
      s[i] = (i >= first) && (i < first + nbytes);
    end
    return s;
  endfunction

  // Offset must be a multiple of the access size; oversize accesses never fit.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] mask;
    logic bad;
    mask = OFF_W'((32'd1 << size) - 32'd1);
    if (size > MAX_SIZE) begin
      bad = 1'b1;
    end else begin
      bad = ((off & mask) != {OFF_W{1'b0}});
    end
    return bad;
  endfunction

  // Shift the addressed bytes down to bit 0 and sign/zero-extend them.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] raw,
                                                        input logic [1:0] size,
                                                        input logic [OFF_W-1:0] off,
                                                        input logic sext);
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] res;
    logic sbit;
    int nbits;
    sh    = raw >> {off, 3'b000};
    nbits = 32'sd8 << size;
    if (nbits > DATA_WIDTH) begin
      nbits = DATA_WIDTH;
    end else begin
      nbits = nbits;
    end
    sbit = sext & sh[nbits-1];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      res[i] = (i < nbits) ? sh[i] : sbit;
    end
    return res;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_write;
  logic                    r_sign;
  logic [1:0]              r_size;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_flushed;
  logic [CNT_W-1:0]        r_wait_cnt;
  logic                    r_ram_en;
  logic [LANES-1:0]        r_ram_we;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [DATA_WIDTH-1:0]   r_ram_wdata;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic                    r_exc_valid;
  logic [1:0]              r_exc_code;
  logic [ADDR_WIDTH-1:0]   r_exc_addr;

  logic                    w_take;
  logic                    w_start;
  logic                    w_misaligned;
  logic [OFF_W-1:0]        w_req_off;
  logic                    w_flush_seen;
  logic                    w_flushed_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_ram_en_nxt;
  logic [LANES-1:0]        w_ram_we_nxt;
  logic [ADDR_WIDTH-1:0]   w_ram_addr_nxt;
  logic [DATA_WIDTH-1:0]   w_ram_wdata_nxt;
  logic                    w_resp_valid_nxt;
  logic [DATA_WIDTH-1:0]   w_resp_data_nxt;
  logic                    w_exc_valid_nxt;
  logic [1:0]              w_exc_code_nxt;
  logic [ADDR_WIDTH-1:0]   w_exc_addr_nxt;

  assign w_req_off    = req_addr[OFF_W-1:0];
  assign w_take       = req_valid & (r_state == S_IDLE) & ~flush;
  assign w_misaligned = is_misaligned(req_size, w_req_off);
  assign w_flush_seen = r_flushed | flush;

  // Next-state and next-output decode for the IDLE/WAIT/RESP controller.
  always_comb begin
    w_state_nxt      = r_state;
    w_start          = 1'b0;
    w_flushed_nxt    = r_flushed;
    w_cnt_nxt        = r_wait_cnt;
    w_ram_en_nxt     = r_ram_en;
    w_ram_we_nxt     = r_ram_we;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_wdata_nxt  = r_ram_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = {DATA_WIDTH{1'b0}};
    w_exc_valid_nxt  = 1'b0;
    w_exc_code_nxt   = 2'd0;
    w_exc_addr_nxt   = {ADDR_WIDTH{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          if (w_misaligned) begin
            // No bus activity; report the fault and stay idle.
            w_exc_valid_nxt = 1'b1;
            w_exc_code_nxt  = req_write ? 2'd2 : 2'd1;
            w_exc_addr_nxt  = req_addr;
          end else begin
            w_state_nxt     = S_WAIT;
            w_start         = 1'b1;
            w_flushed_nxt   = 1'b0;
            w_cnt_nxt       = {CNT_W{1'b0}};
            w_ram_en_nxt    = 1'b1;
            w_ram_addr_nxt  = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            w_ram_we_nxt    = req_write ? lane_strobe(req_size, w_req_off) : {LANES{1'b0}};
            w_ram_wdata_nxt = req_write ? (req_wdata << {w_req_off, 3'b000}) : {DATA_WIDTH{1'b0}};
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_flushed_nxt = w_flush_seen;
        if (ram_ready) begin
          w_state_nxt      = S_RESP;
          w_ram_en_nxt     = 1'b0;
          w_ram_we_nxt     = {LANES{1'b0}};
          w_ram_addr_nxt   = {ADDR_WIDTH{1'b0}};
          w_ram_wdata_nxt  = {DATA_WIDTH{1'b0}};
          w_resp_valid_nxt = ~w_flush_seen;
          if (r_write) begin
            w_resp_data_nxt = {DATA_WIDTH{1'b0}};
          end else begin
            w_resp_data_nxt = load_extend(ram_read_data, r_size, r_addr[OFF_W-1:0], r_sign);
          end
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt     = S_IDLE;
          w_ram_en_nxt    = 1'b0;
          w_ram_we_nxt    = {LANES{1'b0}};
          w_ram_addr_nxt  = {ADDR_WIDTH{1'b0}};
          w_ram_wdata_nxt = {DATA_WIDTH{1'b0}};
          if (w_flush_seen) begin
            w_exc_valid_nxt = 1'b0;
          end else begin
            w_exc_valid_nxt = 1'b1;
            w_exc_code_nxt  = 2'd3;
            w_exc_addr_nxt  = r_addr;
          end
        end else begin
          w_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_ram_en_nxt    = 1'b0;
        w_ram_we_nxt    = {LANES{1'b0}};
        w_ram_addr_nxt  = {ADDR_WIDTH{1'b0}};
        w_ram_wdata_nxt = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture, wait counter and registered bus/response/exception outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write      <= 1'b0;
      r_sign       <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= {ADDR_WIDTH{1'b0}};
      r_flushed    <= 1'b0;
      r_wait_cnt   <= {CNT_W{1'b0}};
      r_ram_en     <= 1'b0;
      r_ram_we     <= {LANES{1'b0}};
      r_ram_addr   <= {ADDR_WIDTH{1'b0}};
      r_ram_wdata  <= {DATA_WIDTH{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_data  <= {DATA_WIDTH{1'b0}};
      r_exc_valid  <= 1'b0;
      r_exc_code   <= 2'd0;
      r_exc_addr   <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (w_start) begin
        r_write <= req_write;
        r_sign  <= req_sign_ext;
        r_size  <= req_size;
        r_addr  <= req_addr;
      end
      r_flushed    <= w_flushed_nxt;
      r_wait_cnt   <= w_cnt_nxt;
      r_ram_en     <= w_ram_en_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_wdata  <= w_ram_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_exc_valid  <= w_exc_valid_nxt;
      r_exc_code   <= w_exc_code_nxt;
      r_exc_addr   <= w_exc_addr_nxt;
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign ram_en         = r_ram_en;
  assign ram_write_en   = r_ram_we;
  assign ram_addr       = r_ram_addr;
  assign ram_write_data = r_ram_wdata;
  // A flush arriving in the RESP cycle itself still squashes the pulse.
  assign resp_valid     = r_resp_valid & ~flush;
  assign resp_data      = r_resp_data;
  assign exc_valid      = r_exc_valid;
  assign exc_code       = r_exc_code;
  assign exc_addr       = r_exc_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 32-bit instance (TIMEOUT=4) and a
// 64-bit instance, directed vectors with hand-computed expectations.
module tb_mem_access_unit;

  localparam int TO32 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        req_valid32, req_write32, req_sign32, flush32, ram_ready32;
  logic [1:0]  req_size32;
  logic [31:0] req_addr32, req_wdata32, ram_rdata32;
  logic        req_ready32, ram_en32, resp_valid32, exc_valid32;
  logic [3:0]  ram_we32;
  logic [31:0] ram_addr32, ram_wdata32, resp_data32, exc_addr32;
  logic [1:0]  exc_code32;

  // 64-bit instance signals
  logic        req_valid64, req_write64, req_sign64, flush64, ram_ready64;
  logic [1:0]  req_size64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64, ram_rdata64;
  logic        req_ready64, ram_en64, resp_valid64, exc_valid64;
  logic [7:0]  ram_we64;
  logic [31:0] ram_addr64, exc_addr64;
  logic [63:0] ram_wdata64, resp_data64;
  logic [1:0]  exc_code64;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO32)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_write(req_write32),
    .req_sign_ext(req_sign32), .req_size(req_size32), .req_addr(req_addr32),
    .req_wdata(req_wdata32), .flush(flush32),
    .ram_en(ram_en32), .ram_write_en(ram_we32), .ram_addr(ram_addr32),
    .ram_write_data(ram_wdata32), .ram_ready(ram_ready32), .ram_read_data(ram_rdata32),
    .resp_valid(resp_valid32), .resp_data(resp_data32),
    .exc_valid(exc_valid32), .exc_code(exc_code32), .exc_addr(exc_addr32)
  );

  mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(255)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_write(req_write64),
    .req_sign_ext(req_sign64), .req_size(req_size64), .req_addr(req_addr64),
    .req_wdata(req_wdata64), .flush(flush64),
    .ram_en(ram_en64), .ram_write_en(ram_we64), .ram_addr(ram_addr64),
    .ram_write_data(ram_wdata64), .ram_ready(ram_ready64), .ram_read_data(ram_rdata64),
    .resp_valid(resp_valid64), .resp_data(resp_data64),
    .exc_valid(exc_valid64), .exc_code(exc_code64), .exc_addr(exc_addr64)
  );

  typedef struct {
    logic        is_exc;
    logic [1:0]  code;
    logic [63:0] data;
    logic [31:0] addr;
  } ev_t;

  typedef struct {
    logic [7:0]  we;
    logic [31:0] addr;
    logic [63:0] wd;
    int          nwait;
  } bus_t;

  ev_t  evq32[$];
  ev_t  evq64[$];
  bus_t busq32[$];
  bus_t busq64[$];

  bus_t b_cur [2];
  int   b_cnt [2];
  bit   b_have [2];
  bit   b_prev [2];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy_of(input int s);
    return (s == 0) ? req_ready32 : req_ready64;
  endfunction

  function automatic logic rv_of(input int s);
    return (s == 0) ? resp_valid32 : resp_valid64;
  endfunction

  task automatic drive_req(input int s, input logic v, input logic w, input logic sx,
                           input logic [1:0] sz, input logic [31:0] a, input logic [63:0] wd);
    if (s == 0) begin
      req_valid32 = v; req_write32 = w; req_sign32 = sx;
      req_size32 = sz; req_addr32 = a; req_wdata32 = wd[31:0];
    end else begin
      req_valid64 = v; req_write64 = w; req_sign64 = sx;
      req_size64 = sz; req_addr64 = a; req_wdata64 = wd;
    end
  endtask

  task automatic set_ram(input int s, input logic rdy, input logic [63:0] rd, input logic fl);
    if (s == 0) begin
      ram_ready32 = rdy; ram_rdata32 = rd[31:0]; flush32 = fl;
    end else begin
      ram_ready64 = rdy; ram_rdata64 = rd; flush64 = fl;
    end
  endtask

  // One transaction. dly: ram_ready=0 WAIT cycles before ready (-1 = never).
  // flk: WAIT cycle index to pulse flush (dly+1 = the RESP cycle, -1 = none).
  // ev: 0 none, 1 response (exp_d), 2 exception (exp_c, addr = a).
  task automatic issue(input int s, input logic w, input logic sx, input logic [1:0] sz,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       input int dly, input int flk, input int ev,
                       input logic [63:0] exp_d, input logic [1:0] exp_c,
                       input logic [7:0] b_we, input logic [31:0] b_addr, input logic [63:0] b_wd);
    bit   has_bus;
    int   n;
    bus_t b;
    ev_t  e;
    has_bus = !(ev == 2 && exp_c != 2'd3);
    n = (dly >= 0) ? dly + 1 : TO32;
    if (has_bus) begin
      b = '{we: b_we, addr: b_addr, wd: b_wd, nwait: n};
      if (s == 0) busq32.push_back(b); else busq64.push_back(b);
    end
    if (ev != 0) begin
      e = '{is_exc: (ev == 2), code: exp_c, data: exp_d, addr: ((ev == 2) ? a : 32'h0)};
      if (s == 0) evq32.push_back(e); else evq64.push_back(e);
    end
    drive_req(s, 1'b1, w, sx, sz, a, wd);
    @(posedge clk); #1;
    drive_req(s, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    if (has_bus) begin
      for (int k = 0; k < n; k++) begin
        set_ram(s, (k == dly), rd, (k == flk));
        @(posedge clk); #1;
      end
      set_ram(s, 1'b0, 64'h0, 1'b0);
      if (dly >= 0) begin
        set_ram(s, 1'b0, 64'h0, (flk == dly + 1));
        #1;
        chk("resp_in_resp_cycle", rv_of(s), ((ev == 1) ? 1'b1 : 1'b0));
        @(posedge clk); #1;
        set_ram(s, 1'b0, 64'h0, 1'b0);
      end
      chk("req_ready_back", rdy_of(s), 1'b1);
    end
  endtask

  task automatic ev_check(input int s, input logic rv, input logic xv, input logic [63:0] d,
                          input logic [1:0] c, input logic [31:0] a);
    ev_t e;
    bit  empty;
    if (rv || xv) begin
      chk("resp_exc_exclusive", rv & xv, 1'b0);
      empty = (s == 0) ? (evq32.size() == 0) : (evq64.size() == 0);
      if (empty) begin
        chk("unexpected_output", {rv, xv}, 2'b00);
      end else begin
        if (s == 0) e = evq32.pop_front(); else e = evq64.pop_front();
        chk("event_kind", xv, e.is_exc);
        if (e.is_exc) begin
          chk("exc_code", c, e.code);
          chk("exc_addr", a, e.addr);
        end else begin
          chk("resp_data", d, e.data);
        end
      end
    end
  endtask

  task automatic bus_check(input int s, input logic en, input logic [7:0] we,
                           input logic [31:0] a, input logic [63:0] wd);
    bit empty;
    if (en && !b_prev[s]) begin
      empty = (s == 0) ? (busq32.size() == 0) : (busq64.size() == 0);
      if (empty) begin
        chk("unexpected_bus", en, 1'b0);
      end else begin
        if (s == 0) b_cur[s] = busq32.pop_front(); else b_cur[s] = busq64.pop_front();
        b_cnt[s]  = 0;
        b_have[s] = 1'b1;
      end
    end
    if (en && b_have[s]) begin
      chk("bus_write_en", we, b_cur[s].we);
      chk("bus_addr", a, b_cur[s].addr);
      chk("bus_write_data", wd, b_cur[s].wd);
      b_cnt[s]++;
    end else if (!en && b_prev[s] && b_have[s]) begin
      chk("bus_wait_cycles", b_cnt[s], b_cur[s].nwait);
      b_have[s] = 1'b0;
    end
    if (!en) begin
      chk("bus_idle_zero", {a, we, wd}, 104'h0);
    end
    b_prev[s] = en;
  endtask

  // Monitor: samples both DUTs on the falling edge and checks against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        b_prev[i] = 1'b0;
        b_have[i] = 1'b0;
      end
    end else begin
      ev_check(0, resp_valid32, exc_valid32, {32'h0, resp_data32}, exc_code32, exc_addr32);
      ev_check(1, resp_valid64, exc_valid64, resp_data64, exc_code64, exc_addr64);
      bus_check(0, ram_en32, {4'h0, ram_we32}, ram_addr32, {32'h0, ram_wdata32});
      bus_check(1, ram_en64, ram_we64, ram_addr64, ram_wdata64);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    drive_req(1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    set_ram(0, 1'b0, 64'h0, 1'b0);
    set_ram(1, 1'b0, 64'h0, 1'b0);
    #1 rst = 1'b0;
    #2;
    chk("reset_req_ready32", req_ready32, 1'b1);
    chk("reset_outputs32", {ram_en32, ram_we32, ram_addr32, ram_wdata32, resp_valid32,
                            resp_data32, exc_valid32, exc_code32, exc_addr32}, 128'h0);
    chk("reset_req_ready64", req_ready64, 1'b1);
    chk("reset_outputs64", {ram_en64, ram_we64, ram_wdata64, resp_valid64, exc_valid64}, 128'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // byte store 0x1003, ready on first WAIT cycle
    issue(0, 1'b1, 1'b0, 2'd0, 32'h1003, 64'hAB, 64'h0, 0, -1, 1, 64'h0, 2'd0,
          8'h08, 32'h1000, 64'hAB000000);
    // signed / unsigned halfword loads at 0x2002, ready after 3 wait cycles
    issue(0, 1'b0, 1'b1, 2'd1, 32'h2002, 64'h0, 64'h80011234, 3, -1, 1, 64'hFFFF8001, 2'd0,
          8'h00, 32'h2000, 64'h0);
    issue(0, 1'b0, 1'b0, 2'd1, 32'h2002, 64'h0, 64'h80011234, 3, -1, 1, 64'h00008001, 2'd0,
          8'h00, 32'h2000, 64'h0);
    // halfword and word stores
    issue(0, 1'b1, 1'b0, 2'd1, 32'h0012, 64'hBEEF, 64'h0, 1, -1, 1, 64'h0, 2'd0,
          8'h0C, 32'h0010, 64'hBEEF0000);
    issue(0, 1'b1, 1'b0, 2'd2, 32'h0020, 64'hCAFEF00D, 64'h0, 0, -1, 1, 64'h0, 2'd0,
          8'h0F, 32'h0020, 64'hCAFEF00D);
    // misaligned and illegal-size requests
    issue(0, 1'b0, 1'b0, 2'd2, 32'h3001, 64'h0, 64'h0, 0, -1, 2, 64'h0, 2'd1, 8'h0, 32'h0, 64'h0);
    issue(0, 1'b1, 1'b0, 2'd2, 32'h3002, 64'h0, 64'h0, 0, -1, 2, 64'h0, 2'd2, 8'h0, 32'h0, 64'h0);
    issue(0, 1'b0, 1'b0, 2'd1, 32'h3003, 64'h0, 64'h0, 0, -1, 2, 64'h0, 2'd1, 8'h0, 32'h0, 64'h0);
    issue(0, 1'b0, 1'b0, 2'd3, 32'h3000, 64'h0, 64'h0, 0, -1, 2, 64'h0, 2'd1, 8'h0, 32'h0, 64'h0);
    // timeout: ram_ready never asserted
    issue(0, 1'b0, 1'b0, 2'd2, 32'h5000, 64'h0, 64'h0, -1, -1, 2, 64'h0, 2'd3,
          8'h00, 32'h5000, 64'h0);
    // flush in 2nd WAIT cycle, ready in 4th: no response, then a normal load
    issue(0, 1'b0, 1'b0, 2'd2, 32'h6004, 64'h0, 64'h11111111, 3, 1, 0, 64'h0, 2'd0,
          8'h00, 32'h6004, 64'h0);
    issue(0, 1'b0, 1'b0, 2'd2, 32'h4000, 64'h0, 64'hDEADBEEF, 0, -1, 1, 64'hDEADBEEF, 2'd0,
          8'h00, 32'h4000, 64'h0);
    // flush in the RESP cycle, then the same byte load signed
    issue(0, 1'b0, 1'b0, 2'd0, 32'h7001, 64'h0, 64'h0000C300, 1, 2, 0, 64'h0, 2'd0,
          8'h00, 32'h7000, 64'h0);
    issue(0, 1'b0, 1'b1, 2'd0, 32'h7001, 64'h0, 64'h0000C300, 1, -1, 1, 64'hFFFFFFC3, 2'd0,
          8'h00, 32'h7000, 64'h0);

    // flush with req_valid in IDLE drops the request
    drive_req(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0040, 64'h0);
    flush32 = 1'b1;
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    flush32 = 1'b0;
    chk("flush_idle_no_bus", ram_en32, 1'b0);
    chk("flush_idle_ready", req_ready32, 1'b1);

    // ram_ready outside WAIT is ignored
    ram_ready32 = 1'b1;
    @(posedge clk); #1;
    ram_ready32 = 1'b0;
    chk("stray_ready_no_resp", resp_valid32, 1'b0);

    // 64-bit: doubleword load, byte store, signed word load, misaligned doubleword
    issue(1, 1'b0, 1'b0, 2'd3, 32'h0008, 64'h0, 64'h1122334455667788, 0, -1, 1,
          64'h1122334455667788, 2'd0, 8'h00, 32'h0008, 64'h0);
    issue(1, 1'b1, 1'b0, 2'd0, 32'h000D, 64'h5A, 64'h0, 0, -1, 1, 64'h0, 2'd0,
          8'h20, 32'h0008, 64'h00005A0000000000);
    issue(1, 1'b0, 1'b1, 2'd2, 32'h0004, 64'h0, 64'h89ABCDEF01234567, 2, -1, 1,
          64'hFFFFFFFF89ABCDEF, 2'd0, 8'h00, 32'h0000, 64'h0);
    issue(1, 1'b0, 1'b0, 2'd3, 32'h0004, 64'h0, 64'h0, 0, -1, 2, 64'h0, 2'd1,
          8'h0, 32'h0, 64'h0);

    // reset asserted in the 2nd WAIT cycle of a load: bus drops at once, no response
    busq32.push_back('{we: 8'h00, addr: 32'h0100, wd: 64'h0, nwait: 0});
    drive_req(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0100, 64'h0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset_in_wait_ram_en", ram_en32, 1'b0);
    chk("reset_in_wait_ready", req_ready32, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, 1'b0, 2'd0, 32'h0102, 64'h0, 64'h00770000, 0, -1, 1, 64'h00000077, 2'd0,
          8'h00, 32'h0100, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("events32_drained", evq32.size(), 0);
    chk("events64_drained", evq64.size(), 0);
    chk("bus32_drained", busq32.size(), 0);
    chk("bus64_drained", busq64.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
